audio_compressor_sched: RTL and testbench

- Per-sample frame scheduler in front of the shared stereo dynamic compressor.
- On each sample strobe it polls NUM_SRC sound sources in a round-robin gather (valid/ready per source) and sums them into one saturated INPUT_WIDTH stereo mix.
- It then drives the compressor's enable for a fixed settle window, captures the compressed result and presents it downstream with a one-cycle valid pulse.
- Sits between the sound-source mixers and the audio output/serializer.

---
 rtl/audio_compressor_sched.sv | 190 +++++++++++++++++++
 tb/tb_audio_compressor_sched.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_compressor_sched.sv
// Per-sample frame scheduler: round-robin source gather, saturated stereo mix, timed compressor
// enable window and result capture. Optional fade-in: define AUDIO_COMPRESSOR_SCHED_SOFTSTART_EN.
module audio_compressor_sched #(
    parameter int unsigned NUM_SRC      = 4,
    parameter int unsigned SRC_WIDTH    = 16,
    parameter int unsigned INPUT_WIDTH  = 24,
    parameter int unsigned OUTPUT_WIDTH = 16,
    parameter int unsigned COMP_CYCLES  = 3
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         sample_strobe_i,
    input  logic                         bypass_i,
    input  logic                         clear_status_i,
    input  logic [NUM_SRC-1:0]           src_valid_i,
    input  logic [NUM_SRC*SRC_WIDTH-1:0] src_l_i,
    input  logic [NUM_SRC*SRC_WIDTH-1:0] src_r_i,
    output logic [NUM_SRC-1:0]           src_ready_o,
    output logic                         comp_enable_o,
    output logic [INPUT_WIDTH-1:0]       comp_in_l_o,
    output logic [INPUT_WIDTH-1:0]       comp_in_r_o,
    input  logic [OUTPUT_WIDTH-1:0]      comp_out_l_i,
    input  logic [OUTPUT_WIDTH-1:0]      comp_out_r_i,
    output logic                         out_valid_o,
    output logic [OUTPUT_WIDTH-1:0]      out_l_o,
    output logic [OUTPUT_WIDTH-1:0]      out_r_o,
    output logic                         busy_o,
    output logic                         overrun_o,
    output logic [NUM_SRC-1:0]           underrun_o
);
    localparam int unsigned AccW  = INPUT_WIDTH + 3;
    localparam int unsigned SlotW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned CntW  = $clog2(COMP_CYCLES + 1);
    localparam int unsigned ExtW  = INPUT_WIDTH - OUTPUT_WIDTH + 1;
    localparam logic signed [AccW-1:0] InMax = {4'b0000, {(INPUT_WIDTH-1){1'b1}}};
    localparam logic signed [AccW-1:0] InMin = {4'b1111, {(INPUT_WIDTH-1){1'b0}}};
    localparam logic signed [INPUT_WIDTH-1:0] OutMax = {{ExtW{1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
    localparam logic signed [INPUT_WIDTH-1:0] OutMin = {{ExtW{1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StGather, StCompress, StCapture} state_e;

    state_e                        state_q, state_d;
    logic [SlotW-1:0]              slot_q, slot_d;
    logic [CntW-1:0]               cnt_q, cnt_d;
    logic                          bypass_q;
    logic signed [AccW-1:0]        acc_l_q, acc_r_q;
    logic signed [INPUT_WIDTH-1:0] comp_in_l_q, comp_in_r_q;
    logic [OUTPUT_WIDTH-1:0]       out_l_q, out_r_q;
    logic                          out_valid_q;
    logic                          overrun_q;
    logic [NUM_SRC-1:0]            underrun_q;

    function automatic logic signed [INPUT_WIDTH-1:0] sat_in(input logic signed [AccW-1:0] v);
        if (v > InMax) return InMax[INPUT_WIDTH-1:0];
        if (v < InMin) return InMin[INPUT_WIDTH-1:0];
        return v[INPUT_WIDTH-1:0];
    endfunction

    function automatic logic signed [OUTPUT_WIDTH-1:0] clip_out(
        input logic signed [INPUT_WIDTH-1:0] v);
        if (v > OutMax) return OutMax[OUTPUT_WIDTH-1:0];
        if (v < OutMin) return OutMin[OUTPUT_WIDTH-1:0];
        return v[OUTPUT_WIDTH-1:0];
    endfunction

    logic signed [SRC_WIDTH-1:0]    sel_l, sel_r;
    logic                           sel_valid, last_slot;
    logic signed [AccW-1:0]         sum_l, sum_r;
    logic [NUM_SRC-1:0]             slot_onehot, under_set;
    logic signed [OUTPUT_WIDTH-1:0] cap_l, cap_r, fin_l, fin_r;

    assign sel_l       = src_l_i[slot_q*SRC_WIDTH +: SRC_WIDTH];
    assign sel_r       = src_r_i[slot_q*SRC_WIDTH +: SRC_WIDTH];
    assign sel_valid   = src_valid_i[slot_q];
    assign last_slot   = (slot_q == SlotW'(NUM_SRC - 1));
    assign slot_onehot = NUM_SRC'(1) << slot_q;
    // An invalid slot contributes nothing but is still consumed and flagged.
    assign sum_l = acc_l_q + (sel_valid ? {{(AccW-SRC_WIDTH){sel_l[SRC_WIDTH-1]}}, sel_l} : '0);
    assign sum_r = acc_r_q + (sel_valid ? {{(AccW-SRC_WIDTH){sel_r[SRC_WIDTH-1]}}, sel_r} : '0);
    assign under_set = (state_q == StGather && !sel_valid) ? slot_onehot : '0;

    assign cap_l = bypass_q ? clip_out(comp_in_l_q) : comp_out_l_i;
    assign cap_r = bypass_q ? clip_out(comp_in_r_q) : comp_out_r_i;

`ifdef AUDIO_COMPRESSOR_SCHED_SOFTSTART_EN
    localparam int unsigned ProdW = OUTPUT_WIDTH + 10;
    logic [8:0]       ramp_q;
    logic [ProdW-1:0] prod_l, prod_r;
    // Low ProdW bits of an unsigned product equal the signed product for sign-extended operands.
    assign prod_l = {{10{cap_l[OUTPUT_WIDTH-1]}}, cap_l} * {{(OUTPUT_WIDTH+1){1'b0}}, ramp_q};
    assign prod_r = {{10{cap_r[OUTPUT_WIDTH-1]}}, cap_r} * {{(OUTPUT_WIDTH+1){1'b0}}, ramp_q};
    assign fin_l  = prod_l[OUTPUT_WIDTH+7:8];
    assign fin_r  = prod_r[OUTPUT_WIDTH+7:8];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ramp_q <= '0;
        end else if (state_q == StCapture && ramp_q != 9'd256) begin
            ramp_q <= ramp_q + 9'd1;
        end
    end
`else
    assign fin_l = cap_l;
    assign fin_r = cap_r;
`endif

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (sample_strobe_i) begin
                    state_d = StGather;
                    slot_d  = '0;
                end
            end
            StGather: begin
                slot_d = slot_q + 1'b1;
                if (last_slot) begin
                    slot_d  = '0;
                    cnt_d   = '0;
                    state_d = bypass_q ? StCapture : StCompress;
                end
            end
            StCompress: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(COMP_CYCLES - 1)) state_d = StCapture;
            end
            StCapture: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= StIdle;
            slot_q      <= '0;
            cnt_q       <= '0;
            bypass_q    <= 1'b0;
            acc_l_q     <= '0;
            acc_r_q     <= '0;
            comp_in_l_q <= '0;
            comp_in_r_q <= '0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            underrun_q  <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            cnt_q       <= cnt_d;
            out_valid_q <= (state_q == StCapture);
            // Set beats clear when both happen in the same cycle.
            overrun_q   <= (overrun_q & ~clear_status_i) |
                           (sample_strobe_i & (state_q != StIdle));
            underrun_q  <= (underrun_q & ~{NUM_SRC{clear_status_i}}) | under_set;
            if (state_q == StIdle && sample_strobe_i) begin
                acc_l_q  <= '0;
                acc_r_q  <= '0;
                bypass_q <= bypass_i;
            end
            if (state_q == StGather) begin
                acc_l_q <= sum_l;
                acc_r_q <= sum_r;
                if (last_slot) begin
                    comp_in_l_q <= sat_in(sum_l);
                    comp_in_r_q <= sat_in(sum_r);
                end
            end
            if (state_q == StCapture) begin
                out_l_q <= fin_l;
                out_r_q <= fin_r;
            end
        end
    end

    assign src_ready_o   = (state_q == StGather) ? slot_onehot : '0;
    assign comp_enable_o = (state_q == StCompress);
    assign comp_in_l_o   = comp_in_l_q;
    assign comp_in_r_o   = comp_in_r_q;
    assign out_valid_o   = out_valid_q;
    assign out_l_o       = out_l_q;
    assign out_r_o       = out_r_q;
    assign busy_o        = (state_q != StIdle);
    assign overrun_o     = overrun_q;
    assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_audio_compressor_sched.sv
// Bench for audio_compressor_sched: fixed vector table, hand-written corner sequences and
// randomized frames against an arithmetic reference model.
module tb_audio_compressor_sched;
    logic        clk = 1'b0;
    logic        reset_n, strobe, bypass, clear_status;
    logic [3:0]  src_valid, src_ready, underrun;
    logic [63:0] src_l, src_r;
    logic        comp_enable, out_valid, busy, overrun;
    logic [23:0] comp_in_l, comp_in_r;
    logic [15:0] comp_out_l, comp_out_r, out_l, out_r;
    int          comp_shift;
    int          n_tests = 0;
    int          n_fail = 0;
    int          ramp_model = 0;
    logic [3:0]  und_model = 4'b0000;

    typedef struct {
        logic [63:0] l, r;
        logic [3:0]  valid;
        logic        byp;
        int          shift;
        longint      in_l, in_r, out_l, out_r;
    } vec_t;

    vec_t vecs[4];

    audio_compressor_sched dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .sample_strobe_i(strobe),
        .bypass_i       (bypass),
        .clear_status_i (clear_status),
        .src_valid_i    (src_valid),
        .src_l_i        (src_l),
        .src_r_i        (src_r),
        .src_ready_o    (src_ready),
        .comp_enable_o  (comp_enable),
        .comp_in_l_o    (comp_in_l),
        .comp_in_r_o    (comp_in_r),
        .comp_out_l_i   (comp_out_l),
        .comp_out_r_i   (comp_out_r),
        .out_valid_o    (out_valid),
        .out_l_o        (out_l),
        .out_r_o        (out_r),
        .busy_o         (busy),
        .overrun_o      (overrun),
        .underrun_o     (underrun)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] clip16(input longint v);
        if (v > 32767) return 16'h7fff;
        if (v < -32768) return 16'h8000;
        return 16'(v);
    endfunction

    function automatic longint clamp(input longint v, input longint lo, input longint hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic longint scale(input longint raw);
`ifdef AUDIO_COMPRESSOR_SCHED_SOFTSTART_EN
        return (raw * ramp_model) >>> 8;
`else
        return raw;
`endif
    endfunction

    // Compressor stand-in: arithmetic shift of the mix, clipped to the output range.
    always_comb begin
        comp_out_l = clip16(longint'($signed(comp_in_l)) >>> comp_shift);
        comp_out_r = clip16(longint'($signed(comp_in_r)) >>> comp_shift);
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_clear();
        clear_status = 1'b1;
        @(posedge clk); #1;
        clear_status = 1'b0;
    endtask

    // One frame from strobe to T+12; extra_at>0 re-strobes (with clear) at T+extra_at.
    task automatic run_frame(input string name, input vec_t v, input int extra_at);
        int rdy_err = 0;
        int en_cnt = 0;
        int en_first = 0;
        int val_cnt = 0;
        int val_at = 0;
        longint got_l = 0;
        longint got_r = 0;
        longint exp_l, exp_r;
        logic [3:0] exp_rdy;
        src_l = v.l; src_r = v.r; src_valid = v.valid; bypass = v.byp; comp_shift = v.shift;
        strobe = 1'b1;
        @(posedge clk); #1;
        strobe = 1'b0;
        bypass = ~v.byp;
        check({name, " busy"}, longint'(busy), 1);
        for (int k = 1; k <= 12; k++) begin
            if (k == extra_at) begin
                strobe = 1'b1;
                clear_status = 1'b1;
            end
            exp_rdy = (k <= 4) ? 4'(1 << (k - 1)) : 4'b0000;
            if (src_ready !== exp_rdy) rdy_err++;
            if (comp_enable) begin
                en_cnt++;
                if (en_first == 0) en_first = k;
            end
            if (out_valid) begin
                val_cnt++;
                if (val_at == 0) begin
                    val_at = k;
                    got_l = longint'($signed(out_l));
                    got_r = longint'($signed(out_r));
                end
            end
            @(posedge clk); #1;
            strobe = 1'b0;
            clear_status = 1'b0;
        end
        exp_l = scale(v.out_l);
        exp_r = scale(v.out_r);
        if (ramp_model < 256) ramp_model++;
        und_model = und_model | ~v.valid;
        check({name, " ready pattern errors"}, rdy_err, 0);
        check({name, " enable first"}, en_first, v.byp ? 0 : 5);
        check({name, " enable count"}, en_cnt, v.byp ? 0 : 3);
        check({name, " valid latency"}, val_at, v.byp ? 6 : 9);
        check({name, " valid count"}, val_cnt, 1);
        check({name, " out_l"}, got_l, exp_l);
        check({name, " out_r"}, got_r, exp_r);
        check({name, " out_l hold"}, longint'($signed(out_l)), exp_l);
        check({name, " comp_in_l"}, longint'($signed(comp_in_l)), v.in_l);
        check({name, " comp_in_r"}, longint'($signed(comp_in_r)), v.in_r);
        check({name, " idle"}, longint'(busy), 0);
    endtask

    initial begin
        int a_l[4];
        int a_r[4];
        longint s_l, s_r, m_l, m_r;
        vec_t rv;
        int k2;

        vecs[0] = '{pack4(1000, 2000, -500, 100), pack4(10, 20, 30, 40), 4'b1111, 1'b0, 0,
                    2600, 100, 2600, 100};
        vecs[1] = '{pack4(32767, 32767, 32767, 32767), pack4(-32768, -32768, -32768, -32768),
                    4'b1111, 1'b1, 0, 131068, -131072, 32767, -32768};
        vecs[2] = '{pack4(1000, 2000, -500, 100), pack4(10, 20, 30, 40), 4'b1011, 1'b0, 1,
                    3100, 70, 1550, 35};
        vecs[3] = '{pack4(-3, -4, 0, 0), pack4(32767, 32767, 32767, 32767), 4'b1111, 1'b0, 1,
                    -7, 131068, -4, 32767};

        reset_n = 1'b0; strobe = 1'b0; bypass = 1'b0; clear_status = 1'b0;
        src_valid = 4'b0000; src_l = '0; src_r = '0; comp_shift = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", longint'(busy), 0);
        check("reset out_valid", longint'(out_valid), 0);
        check("reset comp_enable", longint'(comp_enable), 0);
        check("reset ready", longint'(src_ready), 0);
        check("reset status", longint'({overrun, underrun}), 0);
        check("reset out/comp_in", longint'({out_l, out_r, comp_in_l, comp_in_r}), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) run_frame($sformatf("vec%0d", i), vecs[i], 0);
        check("underrun after slot-2 miss", longint'(underrun), 4'b0100);
        pulse_clear();
        und_model = 4'b0000;
        check("underrun cleared", longint'(underrun), 0);

        // Strobe while busy, coinciding with a clear: frame unaffected, overrun set.
        run_frame("overrun", vecs[0], 4);
        check("overrun set wins over clear", longint'(overrun), 1);
        pulse_clear();
        check("overrun cleared", longint'(overrun), 0);

        // Back-to-back: a strobe on the out_valid cycle starts the next frame.
        src_l = vecs[0].l; src_r = vecs[0].r; src_valid = 4'b1111; bypass = 1'b0;
        comp_shift = 0;
        strobe = 1'b1;
        @(posedge clk); #1;
        strobe = 1'b0;
        k2 = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 9) begin
                check("b2b first valid", longint'(out_valid), 1);
                strobe = 1'b1;
            end
            if (k > 9 && out_valid && k2 == 0) k2 = k;
            @(posedge clk); #1;
            strobe = 1'b0;
        end
        check("b2b second valid", k2, 18);
        check("b2b no overrun", longint'(overrun), 0);
        for (int i = 0; i < 2; i++) if (ramp_model < 256) ramp_model++;

        // Reset during COMPRESS aborts the frame.
        strobe = 1'b1;
        @(posedge clk); #1;
        strobe = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre-reset compressing", longint'(comp_enable), 1);
        reset_n = 1'b0;
        #1;
        check("abort comp_enable", longint'(comp_enable), 0);
        check("abort busy", longint'(busy), 0);
        check("abort outputs", longint'({out_l, out_r, comp_in_l, comp_in_r, src_ready}), 0);
        k2 = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (out_valid) k2++;
        end
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (out_valid) k2++;
        end
        check("abort no out_valid", k2, 0);
        ramp_model = 0;
        und_model = 4'b0000;
        run_frame("post-reset", vecs[0], 0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                pulse_clear();
                und_model = 4'b0000;
            end
            s_l = 0; s_r = 0;
            rv.valid = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b1111;
            rv.byp   = 1'($urandom_range(0, 1));
            rv.shift = $urandom_range(0, 2);
            for (int i = 0; i < 4; i++) begin
                a_l[i] = int'($urandom_range(0, 65535)) - 32768;
                a_r[i] = int'($urandom_range(0, 65535)) - 32768;
                if (rv.valid[i]) begin
                    s_l += a_l[i];
                    s_r += a_r[i];
                end
            end
            rv.l = pack4(a_l[0], a_l[1], a_l[2], a_l[3]);
            rv.r = pack4(a_r[0], a_r[1], a_r[2], a_r[3]);
            m_l = clamp(s_l, -(64'sd1 <<< 23), (64'sd1 <<< 23) - 1);
            m_r = clamp(s_r, -(64'sd1 <<< 23), (64'sd1 <<< 23) - 1);
            rv.in_l = m_l;
            rv.in_r = m_r;
            rv.out_l = rv.byp ? clamp(m_l, -32768, 32767) : clamp(m_l >>> rv.shift, -32768, 32767);
            rv.out_r = rv.byp ? clamp(m_r, -32768, 32767) : clamp(m_r >>> rv.shift, -32768, 32767);
            run_frame($sformatf("rand%0d", n), rv, 0);
            check($sformatf("rand%0d underrun", n), longint'(underrun), longint'(und_model));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
